// File: rtl/rpc_reg_init_seq.sv
// Boot-time register initialiser for the RPC controller: replays a fixed write table, polls a
// status register until ready, then passes the regbus through to the host master.
module rpc_reg_init_seq #(
   parameter int unsigned AddrWidth   = 48,
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned NumEntries  = 4,
   parameter logic [NumEntries-1:0][AddrWidth-1:0] InitAddr = '0,
   parameter logic [NumEntries-1:0][DataWidth-1:0] InitData = '0,
   parameter logic [AddrWidth-1:0] PollAddr  = '0,
   parameter logic [DataWidth-1:0] PollMask  = {{(DataWidth-1){1'b0}}, 1'b1},
   parameter logic [DataWidth-1:0] PollValue = {{(DataWidth-1){1'b0}}, 1'b1},
   parameter int unsigned PollTimeout = 1024,
   parameter bit          AutoStart   = 1'b1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             start_i,
   output logic                             busy_o,
   output logic                             done_o,
   output logic                             fail_o,
   output logic [$clog2(NumEntries+1)-1:0]  fail_idx_o,
   input  logic [AddrWidth-1:0]             host_addr_i,
   input  logic                             host_write_i,
   input  logic [DataWidth-1:0]             host_wdata_i,
   input  logic [DataWidth/8-1:0]           host_wstrb_i,
   input  logic                             host_valid_i,
   output logic [DataWidth-1:0]             host_rdata_o,
   output logic                             host_error_o,
   output logic                             host_ready_o,
   output logic [AddrWidth-1:0]             reg_addr_o,
   output logic                             reg_write_o,
   output logic [DataWidth-1:0]             reg_wdata_o,
   output logic [DataWidth/8-1:0]           reg_wstrb_o,
   output logic                             reg_valid_o,
   input  logic [DataWidth-1:0]             reg_rdata_i,
   input  logic                             reg_error_i,
   input  logic                             reg_ready_i
);

   localparam int unsigned IdxWidth     = (NumEntries > 1) ? $clog2(NumEntries) : 1;
   localparam int unsigned CntWidth     = $clog2(PollTimeout + 1);
   localparam int unsigned FailIdxWidth = $clog2(NumEntries + 1);
   localparam logic [IdxWidth-1:0]     LastIdx   = IdxWidth'(NumEntries - 1);
   localparam logic [CntWidth-1:0]     LastPoll  = CntWidth'(PollTimeout - 1);
   localparam logic [FailIdxWidth-1:0] PollStepIdx = FailIdxWidth'(NumEntries);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StPoll,
      StDone,
      StFail
   } state_e;

   state_e                  state_q, state_d;
   logic [IdxWidth-1:0]     idx_q, idx_d;
   logic [CntWidth-1:0]     poll_cnt_q, poll_cnt_d;
   logic [FailIdxWidth-1:0] fail_idx_q, fail_idx_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         poll_cnt_q <= '0;
         fail_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         poll_cnt_q <= poll_cnt_d;
         fail_idx_q <= fail_idx_d;
      end
   end

   // Request fields depend only on state/idx, so reg_ready_i never reaches reg_valid_o.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      poll_cnt_d   = poll_cnt_q;
      fail_idx_d   = fail_idx_q;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      fail_o       = 1'b0;
      reg_addr_o   = '0;
      reg_write_o  = 1'b0;
      reg_wdata_o  = '0;
      reg_wstrb_o  = '0;
      reg_valid_o  = 1'b0;
      host_rdata_o = '0;
      host_error_o = 1'b0;
      host_ready_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (AutoStart || start_i) begin
               state_d = StWrite;
            end
         end

         StWrite: begin
            busy_o      = 1'b1;
            reg_valid_o = 1'b1;
            reg_write_o = 1'b1;
            reg_addr_o  = InitAddr[idx_q];
            reg_wdata_o = InitData[idx_q];
            reg_wstrb_o = '1;
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  state_d    = StFail;
                  fail_idx_d = FailIdxWidth'(idx_q);
               end else if (idx_q == LastIdx) begin
                  state_d = StPoll;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         StPoll: begin
            busy_o      = 1'b1;
            reg_valid_o = 1'b1;
            reg_addr_o  = PollAddr;
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  state_d    = StFail;
                  fail_idx_d = PollStepIdx;
               end else if (((reg_rdata_i ^ PollValue) & PollMask) == '0) begin
                  state_d = StDone;
               end else if (poll_cnt_q == LastPoll) begin
                  state_d    = StFail;
                  fail_idx_d = PollStepIdx;
               end else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
               end
            end
         end

         StDone: begin
            done_o       = 1'b1;
            reg_addr_o   = host_addr_i;
            reg_write_o  = host_write_i;
            reg_wdata_o  = host_wdata_i;
            reg_wstrb_o  = host_wstrb_i;
            reg_valid_o  = host_valid_i;
            host_rdata_o = reg_rdata_i;
            host_error_o = reg_error_i;
            host_ready_o = reg_ready_i;
         end

         // The controller is unusable after a failed init; error out host accesses so they never hang.
         StFail: begin
            fail_o       = 1'b1;
            host_error_o = 1'b1;
            host_ready_o = host_valid_i;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign fail_idx_o = fail_idx_q;

endmodule

// File: tb/tb_rpc_reg_init_seq.sv
// Directed bench for rpc_reg_init_seq: one auto-start instance (A) and one start_i-driven instance (B)
// sharing the controller response and host request inputs.
module tb_rpc_reg_init_seq;

   localparam int AW = 48;
   localparam int DW = 32;
   localparam logic [2:0][AW-1:0] InitAddrTb = {48'h300, 48'h200, 48'h100};
   localparam logic [2:0][DW-1:0] InitDataTb = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
   localparam logic [AW-1:0]      PollAddrTb = 48'h40;

   logic          clk;
   logic          rstA, rstB, startA, startB;
   logic [AW-1:0] hostAddr;
   logic          hostWrite, hostValid;
   logic [DW-1:0] hostWdata;
   logic [3:0]    hostWstrb;
   logic [DW-1:0] regRdata;
   logic          regError, regReady;

   logic          busyA, doneA, failA, hostErrorA, hostReadyA, regWriteA, regValidA;
   logic [1:0]    failIdxA;
   logic [DW-1:0] hostRdataA, regWdataA;
   logic [AW-1:0] regAddrA;
   logic [3:0]    regWstrbA;

   logic          busyB, doneB, failB, hostErrorB, hostReadyB, regWriteB, regValidB;
   logic [1:0]    failIdxB;
   logic [DW-1:0] hostRdataB, regWdataB;
   logic [AW-1:0] regAddrB;
   logic [3:0]    regWstrbB;

   int errors = 0;
   int checks = 0;

   rpc_reg_init_seq #(
      .AddrWidth(AW), .DataWidth(DW), .NumEntries(3), .InitAddr(InitAddrTb), .InitData(InitDataTb),
      .PollAddr(PollAddrTb), .PollMask(32'h1), .PollValue(32'h1), .PollTimeout(4), .AutoStart(1'b1)
   ) dutA (
      .clk_i(clk), .rst_ni(rstA), .start_i(startA), .busy_o(busyA), .done_o(doneA), .fail_o(failA),
      .fail_idx_o(failIdxA), .host_addr_i(hostAddr), .host_write_i(hostWrite), .host_wdata_i(hostWdata),
      .host_wstrb_i(hostWstrb), .host_valid_i(hostValid), .host_rdata_o(hostRdataA),
      .host_error_o(hostErrorA), .host_ready_o(hostReadyA), .reg_addr_o(regAddrA), .reg_write_o(regWriteA),
      .reg_wdata_o(regWdataA), .reg_wstrb_o(regWstrbA), .reg_valid_o(regValidA), .reg_rdata_i(regRdata),
      .reg_error_i(regError), .reg_ready_i(regReady)
   );

   rpc_reg_init_seq #(
      .AddrWidth(AW), .DataWidth(DW), .NumEntries(3), .InitAddr(InitAddrTb), .InitData(InitDataTb),
      .PollAddr(PollAddrTb), .PollMask(32'h1), .PollValue(32'h1), .PollTimeout(4), .AutoStart(1'b0)
   ) dutB (
      .clk_i(clk), .rst_ni(rstB), .start_i(startB), .busy_o(busyB), .done_o(doneB), .fail_o(failB),
      .fail_idx_o(failIdxB), .host_addr_i(hostAddr), .host_write_i(hostWrite), .host_wdata_i(hostWdata),
      .host_wstrb_i(hostWstrb), .host_valid_i(hostValid), .host_rdata_o(hostRdataB),
      .host_error_o(hostErrorB), .host_ready_o(hostReadyB), .reg_addr_o(regAddrB), .reg_write_o(regWriteB),
      .reg_wdata_o(regWdataB), .reg_wstrb_o(regWstrbB), .reg_valid_o(regValidB), .reg_rdata_i(regRdata),
      .reg_error_i(regError), .reg_ready_i(regReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkReqA(input string tag, input logic [AW-1:0] addr, input logic write,
                            input logic [DW-1:0] wdata, input logic [3:0] wstrb);
      checkOutput({tag, ".valid"}, regValidA, 1'b1);
      checkOutput({tag, ".write"}, regWriteA, write);
      checkOutput({tag, ".addr"},  regAddrA,  addr);
      checkOutput({tag, ".wdata"}, regWdataA, wdata);
      checkOutput({tag, ".wstrb"}, regWstrbA, wstrb);
      checkOutput({tag, ".busy"},  busyA,     1'b1);
   endtask

   // One transfer on instance A: stall for 'stalls' cycles with the request checked every cycle, then complete it.
   task automatic applyStimulus(input string tag, input logic [AW-1:0] addr, input logic write,
                                input logic [DW-1:0] wdata, input logic [3:0] wstrb, input int stalls,
                                input logic [DW-1:0] rdata, input logic err);
      regReady = 1'b0;
      for (int s = 0; s < stalls; s++) begin
         checkReqA(tag, addr, write, wdata, wstrb);
         stepCycle();
      end
      checkReqA(tag, addr, write, wdata, wstrb);
      regRdata = rdata;
      regError = err;
      regReady = 1'b1;
      stepCycle();
      regReady = 1'b0;
      regError = 1'b0;
      regRdata = '0;
   endtask

   task automatic writeA(input int i, input int stalls, input logic err);
      applyStimulus($sformatf("wr%0d", i), InitAddrTb[i], 1'b1, InitDataTb[i], 4'hF, stalls, '0, err);
   endtask

   task automatic pollA(input int stalls, input logic [DW-1:0] rdata, input logic err);
      applyStimulus("poll", PollAddrTb, 1'b0, '0, 4'h0, stalls, rdata, err);
   endtask

   // Hold A in reset, check the reset values, release between edges; returns in cycle 1 after release.
   task automatic resetA();
      rstA = 1'b0;
      regReady = 1'b0;
      regError = 1'b0;
      regRdata = '0;
      stepCycle();
      stepCycle();
      checkOutput("rst.valid", regValidA, 1'b0);
      checkOutput("rst.write", regWriteA, 1'b0);
      checkOutput("rst.addr",  regAddrA,  '0);
      checkOutput("rst.wdata", regWdataA, '0);
      checkOutput("rst.wstrb", regWstrbA, '0);
      checkOutput("rst.busy",  busyA,     1'b0);
      checkOutput("rst.done",  doneA,     1'b0);
      checkOutput("rst.fail",  failA,     1'b0);
      checkOutput("rst.failidx", failIdxA, '0);
      checkOutput("rst.hready", hostReadyA, 1'b0);
      @(negedge clk);
      rstA = 1'b1;
      stepCycle();
   endtask

   initial begin
      rstA = 1'b0; rstB = 1'b0; startA = 1'b0; startB = 1'b0;
      hostAddr = '0; hostWrite = 1'b0; hostWdata = '0; hostWstrb = '0; hostValid = 1'b0;
      regRdata = '0; regError = 1'b0; regReady = 1'b0;

      // Back-to-back writes and a matching poll with a host request pending the whole time.
      hostValid = 1'b1; hostWrite = 1'b1; hostAddr = 48'h999; hostWdata = 32'h55; hostWstrb = 4'h3;
      resetA();
      checkOutput("t1.hostHeldOff", hostReadyA, 1'b0);
      for (int i = 0; i < 3; i++) writeA(i, 0, 1'b0);
      pollA(0, 32'h1, 1'b0);
      checkOutput("t1.done", doneA, 1'b1);
      checkOutput("t1.busy", busyA, 1'b0);
      checkOutput("t1.fail", failA, 1'b0);
      checkOutput("t1.mirrorAddr", regAddrA, 48'h999);

      // Host pass-through with two cycles of controller stall.
      hostAddr = 48'h10; hostWdata = 32'hDEADBEEF; hostWstrb = 4'hF; hostWrite = 1'b1; hostValid = 1'b1;
      #1;
      checkOutput("pass.addr",  regAddrA,  48'h10);
      checkOutput("pass.wdata", regWdataA, 32'hDEADBEEF);
      checkOutput("pass.wstrb", regWstrbA, 4'hF);
      checkOutput("pass.write", regWriteA, 1'b1);
      checkOutput("pass.valid", regValidA, 1'b1);
      for (int s = 0; s < 2; s++) begin
         stepCycle();
         checkOutput("pass.stallReady", hostReadyA, 1'b0);
         checkOutput("pass.stallAddr", regAddrA, 48'h10);
      end
      regReady = 1'b1; regError = 1'b1; regRdata = 32'h1234;
      #1;
      checkOutput("pass.ready", hostReadyA, 1'b1);
      checkOutput("pass.error", hostErrorA, 1'b1);
      checkOutput("pass.rdata", hostRdataA, 32'h1234);
      stepCycle();
      hostValid = 1'b0; regReady = 1'b0; regError = 1'b0; regRdata = '0;

      // Ready stalls between 0 and 5 cycles on each transfer.
      resetA();
      writeA(0, 2, 1'b0);
      writeA(1, 5, 1'b0);
      writeA(2, 0, 1'b0);
      pollA(3, 32'h1, 1'b0);
      checkOutput("t2.done", doneA, 1'b1);
      checkOutput("t2.valid", regValidA, 1'b0);

      // Error on write 1: write 2 must never be issued and the host gets an immediate error.
      resetA();
      writeA(0, 1, 1'b0);
      writeA(1, 0, 1'b1);
      checkOutput("t3.fail", failA, 1'b1);
      checkOutput("t3.failidx", failIdxA, 2'd1);
      checkOutput("t3.valid", regValidA, 1'b0);
      checkOutput("t3.busy", busyA, 1'b0);
      checkOutput("t3.done", doneA, 1'b0);
      regRdata = 32'hFFFF; hostValid = 1'b1;
      #1;
      checkOutput("t3.hready", hostReadyA, 1'b1);
      checkOutput("t3.herror", hostErrorA, 1'b1);
      checkOutput("t3.hrdata", hostRdataA, '0);
      hostValid = 1'b0;
      #1;
      checkOutput("t3.hreadyIdle", hostReadyA, 1'b0);
      stepCycle();
      checkOutput("t3.noWrite2", regValidA, 1'b0);
      regRdata = '0;

      // Poll timeout after exactly four non-matching reads (bit 0 clear, other bits set).
      resetA();
      for (int i = 0; i < 3; i++) writeA(i, 0, 1'b0);
      for (int p = 0; p < 4; p++) pollA(0, 32'hFFFF_FFFE, 1'b0);
      checkOutput("t4.fail", failA, 1'b1);
      checkOutput("t4.failidx", failIdxA, 2'd3);
      checkOutput("t4.valid", regValidA, 1'b0);

      // Match on the last allowed read is a success.
      resetA();
      for (int i = 0; i < 3; i++) writeA(i, 0, 1'b0);
      for (int p = 0; p < 3; p++) pollA(1, 32'h0, 1'b0);
      pollA(0, 32'h3, 1'b0);
      checkOutput("t5.done", doneA, 1'b1);
      checkOutput("t5.fail", failA, 1'b0);

      // Bus error on the poll read reports the poll step.
      resetA();
      for (int i = 0; i < 3; i++) writeA(i, 0, 1'b0);
      pollA(0, 32'h1, 1'b1);
      checkOutput("t6.fail", failA, 1'b1);
      checkOutput("t6.failidx", failIdxA, 2'd3);
      checkOutput("t6.done", doneA, 1'b0);

      // Manual-start instance: waits for start_i, restarts from entry 0 after a reset mid-WRITE.
      rstA = 1'b0;
      @(negedge clk);
      rstB = 1'b1;
      for (int c = 0; c < 3; c++) begin
         stepCycle();
         checkOutput("b.idleValid", regValidB, 1'b0);
         checkOutput("b.idleBusy", busyB, 1'b0);
      end
      checkOutput("b.idleHready", hostReadyB, 1'b0);
      checkOutput("b.idleHerror", hostErrorB, 1'b0);
      checkOutput("b.idleHrdata", hostRdataB, '0);
      checkOutput("b.idleDone", doneB, 1'b0);
      checkOutput("b.idleFail", failB, 1'b0);
      checkOutput("b.idleFailIdx", failIdxB, '0);
      startB = 1'b1;
      stepCycle();
      startB = 1'b0;
      checkOutput("b.wr0Valid", regValidB, 1'b1);
      checkOutput("b.wr0Addr", regAddrB, 48'h100);
      regReady = 1'b1;
      stepCycle();
      regReady = 1'b0;
      checkOutput("b.wr1Addr", regAddrB, 48'h200);
      checkOutput("b.wr1Wdata", regWdataB, 32'hBBBB0002);
      rstB = 1'b0;
      #1;
      checkOutput("b.rstValid", regValidB, 1'b0);
      checkOutput("b.rstBusy", busyB, 1'b0);
      checkOutput("b.rstAddr", regAddrB, '0);
      @(negedge clk);
      rstB = 1'b1;
      stepCycle();
      checkOutput("b.noAutoStart", regValidB, 1'b0);
      startB = 1'b1;
      stepCycle();
      startB = 1'b0;
      checkOutput("b.restartValid", regValidB, 1'b1);
      checkOutput("b.restartAddr", regAddrB, 48'h100);
      checkOutput("b.restartWdata", regWdataB, 32'hAAAA0001);
      checkOutput("b.restartWrite", regWriteB, 1'b1);
      checkOutput("b.restartWstrb", regWstrbB, 4'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
